scan_ctrl: RTL and testbench

//   Scan sequencer feeding the address counter. Drives the counter's en and done_i; consumes its cnt_o.
//   On start, issues one address beat per valid/ready handshake for num_i beats.

---
 rtl/scan_ctrl.sv | 104 ++++++++++
 tb/tb_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl.sv
// Scan sequencer: one address beat per valid/ready handshake, then a counter clear.
// Optional abort input enabled by defining SCAN_ABORT_EN.
module scan_ctrl #(
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_WIDTH:0]   num_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 ready_i,
`ifdef SCAN_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic                 cnt_en_o,
  output logic                 cnt_clr_o,
  output logic [CNT_WIDTH-1:0] addr_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH:0] L_MAX =
    {1'b1, {CNT_WIDTH{1'b0}}};

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH:0]   r_num_q;
  logic [CNT_WIDTH:0]   w_num_sat;
  logic                 w_ld;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_abort;

`ifdef SCAN_ABORT_EN
  assign w_abort = abort_i & (r_state == RUN);
`else
  assign w_abort = 1'b0;
`endif

  assign w_num_sat = (num_i > L_MAX) ? L_MAX : num_i;
  assign w_ld      = (r_state == IDLE) & start_i;
  assign w_hs      = valid_o & ready_i;
  // num_q >= 1 in RUN, so the decrement cannot underflow there
  assign w_last    = ({1'b0, cnt_i} == (r_num_q - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_num_q <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld) r_num_q <= w_num_sat;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i)
          w_next = (w_num_sat == '0) ? DONE : RUN;
      end
      RUN: begin
        if (w_abort)
          w_next = DONE;
        else if (w_hs && w_last)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    valid_o   = 1'b0;
    cnt_clr_o = 1'b0;
    done_o    = 1'b0;
    busy_o    = 1'b0;
    case (r_state)
      RUN: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
      end
      DONE: begin
        cnt_clr_o = 1'b1;
        done_o    = 1'b1;
        busy_o    = 1'b1;
      end
      default: ;
    endcase
  end

  // An aborted beat is never counted
  assign cnt_en_o = w_hs & ~w_abort;
  assign addr_o   = cnt_i;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl with a behavioural address counter.
// Define SCAN_ABORT_EN to also exercise the abort path.
module tb_scan_ctrl;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [W:0]   num_i;
  logic [W-1:0] cnt;
  logic         ready_i;
  logic         abort_i;
  logic         cnt_en_o;
  logic         cnt_clr_o;
  logic [W-1:0] addr_o;
  logic         valid_o;
  logic         busy_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_ctrl #(.CNT_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .num_i     (num_i),
    .cnt_i     (cnt),
    .ready_i   (ready_i),
`ifdef SCAN_ABORT_EN
    .abort_i   (abort_i),
`endif
    .cnt_en_o  (cnt_en_o),
    .cnt_clr_o (cnt_clr_o),
    .addr_o    (addr_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // External address counter: clear wins, else increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (cnt_clr_o) cnt <= '0;
    else if (cnt_en_o)  cnt <= cnt + 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic ochk(input string tag,
                      input logic v, input logic [31:0] a,
                      input logic e, input logic d,
                      input logic b);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".addr"}, 32'(addr_o), a);
    chk({tag, ".en"}, 32'(cnt_en_o), 32'(e));
    chk({tag, ".clr"}, 32'(cnt_clr_o), 32'(d));
    chk({tag, ".done"}, 32'(done_o), 32'(d));
    chk({tag, ".busy"}, 32'(busy_o), 32'(b));
  endtask

  // Full-ready scan; returns beat count and cycles from start to done
  task automatic run_scan(input string tag, input int n,
                          output int beats, output int lat);
    bit got;
    tick;
    start_i = 1'b1;
    num_i   = (W+1)'(n);
    ready_i = 1'b1;
    tick;
    start_i = 1'b0;
    beats = 0;
    lat   = -1;
    got   = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      smp;
      if (done_o) begin
        got = 1'b1;
        lat = k;
      end else if (valid_o && cnt_en_o) begin
        chk({tag, ".addr"}, 32'(addr_o), 32'(beats));
        beats++;
      end
      tick;
    end
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
  endtask

  int bt;
  int lt;
  int nen;

  initial begin
    bit [0:4] rdy = 5'b10011;
    int       exa [5] = '{0, 1, 1, 1, 2};

    rst_n   = 1'b0;
    start_i = 1'b0;
    num_i   = '0;
    ready_i = 1'b0;
    abort_i = 1'b0;
    #12;
    smp;
    ochk("rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    rst_n = 1'b1;

    // num=4 full ready
    tick;
    start_i = 1'b1;
    num_i   = 8'd4;
    ready_i = 1'b1;
    smp;
    ochk("t2.idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp;
      ochk($sformatf("t2.b%0d", i), 1'b1, 32'(i), 1'b1, 1'b0, 1'b1);
      tick;
    end
    smp;
    ochk("t2.done", 1'b0, 32'd4, 1'b0, 1'b1, 1'b1);
    tick;
    smp;
    ochk("t2.after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // stalled scan num=3
    tick;
    start_i = 1'b1;
    num_i   = 8'd3;
    tick;
    start_i = 1'b0;
    nen = 0;
    for (int i = 0; i < 5; i++) begin
      ready_i = rdy[i];
      smp;
      ochk($sformatf("t3.c%0d", i), 1'b1, 32'(exa[i]),
           rdy[i], 1'b0, 1'b1);
      if (cnt_en_o) nen++;
      tick;
    end
    smp;
    ochk("t3.done", 1'b0, 32'd3, 1'b0, 1'b1, 1'b1);
    chk("t3.en_cnt", 32'(nen), 32'd3);
    tick;

    // boundaries
    run_scan("t4.n0", 0, bt, lt);
    chk("t4.n0.beats", 32'(bt), 32'd0);
    chk("t4.n0.lat", 32'(lt), 32'd0);
    run_scan("t4.n128", 128, bt, lt);
    chk("t4.n128.beats", 32'(bt), 32'd128);
    run_scan("t4.n200", 200, bt, lt);
    chk("t4.n200.beats", 32'(bt), 32'd128);
    smp;
    chk("t4.cnt0", 32'(cnt), 32'd0);

    // start held high through a num=2 scan
    tick;
    start_i = 1'b1;
    num_i   = 8'd2;
    ready_i = 1'b1;
    tick;
    smp;
    ochk("t5.b0", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    tick;
    smp;
    ochk("t5.b1", 1'b1, 32'd1, 1'b1, 1'b0, 1'b1);
    tick;
    smp;
    ochk("t5.done", 1'b0, 32'd2, 1'b0, 1'b1, 1'b1);
    tick;
    smp;
    ochk("t5.idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    start_i = 1'b0;
    smp;
    ochk("t5.rb0", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    tick;
    smp;
    ochk("t5.rb1", 1'b1, 32'd1, 1'b1, 1'b0, 1'b1);
    tick;
    smp;
    ochk("t5.rdone", 1'b0, 32'd2, 1'b0, 1'b1, 1'b1);
    tick;

    // reset mid-RUN
    start_i = 1'b1;
    num_i   = 8'd4;
    tick;
    start_i = 1'b0;
    tick;
    tick;
    smp;
    chk("t1.mid_addr", 32'(addr_o), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    ochk("t1.async", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    smp;
    ochk("t1.rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick;
    smp;
    ochk("t1.post", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_ABORT_EN
    tick;
    start_i = 1'b1;
    num_i   = 8'd10;
    ready_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp;
      ochk($sformatf("t6.b%0d", i), 1'b1, 32'(i), 1'b1, 1'b0, 1'b1);
      tick;
    end
    abort_i = 1'b1;
    smp;
    ochk("t6.abort", 1'b1, 32'd3, 1'b0, 1'b0, 1'b1);
    tick;
    abort_i = 1'b0;
    smp;
    ochk("t6.done", 1'b0, 32'd3, 1'b0, 1'b1, 1'b1);
    tick;
    smp;
    ochk("t6.after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Counter enable and clear must never coincide
  always @(negedge clk) begin
    if (rst_n && cnt_en_o && cnt_clr_o) begin
      errors++;
      $display("FAIL en_clr got 1 exp 0");
    end
  end

endmodule
